// File: rtl/icache_pkg.sv
// Shared ICACHE definitions: FSM state encoding and default cache geometry.
package icache_pkg;

  localparam int unsigned DefIndexBits  = 4;
  localparam int unsigned DefOffsetBits = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StRespond
  } icache_state_e;

endpackage

// File: rtl/icache_line_store.sv
// Flop-based tag/valid/data arrays for the direct-mapped icache; lookups read the flops directly,
// refill writes one word per cycle, and reset bulk-clears every valid bit.
module icache_line_store #(
  parameter int unsigned INDEX_BITS  = 4,
  parameter int unsigned OFFSET_BITS = 2,
  parameter int unsigned TAG_BITS    = 30 - INDEX_BITS - OFFSET_BITS
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [INDEX_BITS-1:0]  rd_index,
  input  logic [OFFSET_BITS-1:0] rd_offset,
  output logic                   rd_valid,
  output logic [TAG_BITS-1:0]    rd_tag,
  output logic [31:0]            rd_word,
  input  logic                   wr_en,
  input  logic [INDEX_BITS-1:0]  wr_index,
  input  logic [OFFSET_BITS-1:0] wr_offset,
  input  logic [31:0]            wr_word,
  input  logic                   tag_we,
  input  logic [TAG_BITS-1:0]    wr_tag
);

  localparam int unsigned Lines = 1 << INDEX_BITS;
  localparam int unsigned Words = Lines << OFFSET_BITS;

  logic [Lines-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [Lines];
  logic [31:0]         data_q [Words];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: nothing reads them while the valid bit is clear.
  always_ff @(posedge clk_in) begin
    if (tag_we) begin
      tag_q[wr_index] <= wr_tag;
    end
    if (wr_en) begin
      data_q[{wr_index, wr_offset}] <= wr_word;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_word  = data_q[{rd_index, rd_offset}];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with word-by-word line refill.
// Define ICACHE_PERF_EN to add hit_count/miss_count performance counters.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = DefIndexBits,
  parameter int unsigned OFFSET_BITS = DefOffsetBits
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        to_icache,
  input  logic [31:0] pc_to_icache,
  output logic        have_result,
  output logic [31:0] inst_from_icache,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned TagBits = 30 - INDEX_BITS - OFFSET_BITS;

  icache_state_e state_q, state_d;
  logic [29:0]            req_q, req_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic                   have_q, have_d;
  logic [31:0]            inst_q, inst_d;
  logic                   mem_req_q, mem_req_d;
  logic [31:0]            mem_addr_q, mem_addr_d;

  logic [TagBits-1:0]     lk_tag, req_tag, rd_tag;
  logic [INDEX_BITS-1:0]  lk_index, req_index, rd_index;
  logic [OFFSET_BITS-1:0] lk_offset, req_offset, rd_offset;
  logic                   rd_valid, hit, wr_en, tag_we;
  logic [31:0]            rd_word;
  logic                   unused_pc_lsb;

  assign unused_pc_lsb = ^pc_to_icache[1:0];

  assign lk_tag     = pc_to_icache[31 -: TagBits];
  assign lk_index   = pc_to_icache[OFFSET_BITS+2 +: INDEX_BITS];
  assign lk_offset  = pc_to_icache[2 +: OFFSET_BITS];
  assign req_tag    = req_q[29 -: TagBits];
  assign req_index  = req_q[OFFSET_BITS +: INDEX_BITS];
  assign req_offset = req_q[OFFSET_BITS-1:0];

  // Idle looks up the incoming pc; otherwise the store serves the latched request.
  assign rd_index  = (state_q == StIdle) ? lk_index : req_index;
  assign rd_offset = (state_q == StIdle) ? lk_offset : req_offset;
  assign hit       = rd_valid && (rd_tag == lk_tag);

  icache_line_store #(
    .INDEX_BITS  (INDEX_BITS),
    .OFFSET_BITS (OFFSET_BITS),
    .TAG_BITS    (TagBits)
  ) u_store (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rd_index  (rd_index),
    .rd_offset (rd_offset),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_word   (rd_word),
    .wr_en     (wr_en & rdy_in),
    .wr_index  (req_index),
    .wr_offset (cnt_q),
    .wr_word   (mem_data),
    .tag_we    (tag_we & rdy_in),
    .wr_tag    (req_tag)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    have_d     = 1'b0;
    inst_d     = inst_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    wr_en      = 1'b0;
    tag_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (to_icache) begin
          req_d = pc_to_icache[31:2];
          if (hit) begin
            have_d = 1'b1;
            inst_d = rd_word;
          end else begin
            state_d    = StRefill;
            mem_req_d  = 1'b1;
            mem_addr_d = {lk_tag, lk_index, {OFFSET_BITS{1'b0}}, 2'b00};
            cnt_d      = '0;
          end
        end
      end
      StRefill: begin
        if (mem_done) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + OFFSET_BITS'(1);
          if (cnt_q == {OFFSET_BITS{1'b1}}) begin
            mem_req_d = 1'b0;
            tag_we    = 1'b1;
            state_d   = StRespond;
          end else begin
            mem_addr_d = mem_addr_q + 32'd4;
          end
        end
      end
      StRespond: begin
        have_d  = 1'b1;
        inst_d  = rd_word;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      req_q      <= '0;
      cnt_q      <= '0;
      have_q     <= 1'b0;
      inst_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else if (rdy_in) begin
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      have_q     <= have_d;
      inst_q     <= inst_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign have_result      = have_q;
  assign inst_from_icache = inst_q;
  assign mem_req          = mem_req_q;
  assign mem_addr         = mem_addr_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_q, miss_count_q;
  logic        accept;

  assign accept = (state_q == StIdle) && to_icache;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (rdy_in && accept) begin
      if (hit) begin
        hit_count_q <= hit_count_q + 32'd1;
      end else begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: behavioural cache model compared every cycle plus literal checks.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        to_icache = 1'b0;
  logic [31:0] pc_to_icache = '0;
  logic        have_result;
  logic [31:0] inst_from_icache;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done = 1'b0;
  logic [31:0] mem_data = '0;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  icache dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .to_icache        (to_icache),
    .pc_to_icache     (pc_to_icache),
    .have_result      (have_result),
    .inst_from_icache (inst_from_icache),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_done         (mem_done),
    .mem_data         (mem_data)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count        (hit_count),
    .miss_count       (miss_count)
`endif
  );

  // Backing memory contents: line 0x10 holds 0xA0..0xA3, everything else is address-derived.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h1) return 32'hA0 + {30'd0, a[3:2]};
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory controller: answers each word request after three active cycles.
  int mem_cnt = 0;
  always @(negedge clk_in) begin
    #1;
    if (rst_in || mem_done) begin
      mem_done <= 1'b0;
      mem_cnt  <= 0;
    end else if (rdy_in && mem_req) begin
      if (mem_cnt == 2) begin
        mem_done <= 1'b1;
        mem_data <= mem_word(mem_addr);
      end
      mem_cnt <= mem_cnt + 1;
    end
  end

  logic [31:0] seen [$];
  always @(negedge clk_in) begin
    if (mem_req && (seen.size() == 0 || seen[$] != mem_addr)) seen.push_back(mem_addr);
  end

  // Behavioural model: 16 lines of 16 bytes, index = pc[7:4], tag = pc[31:8].
  logic        m_valid [16];
  logic [23:0] m_tag   [16];
  logic        m_have, m_req, m_resp;
  logic [31:0] m_inst, m_addr, m_pc;
  int          m_left;
  int unsigned m_hits, m_misses;

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 16; i++) m_valid[i] <= 1'b0;
      m_have   <= 1'b0;
      m_inst   <= '0;
      m_req    <= 1'b0;
      m_addr   <= '0;
      m_pc     <= '0;
      m_resp   <= 1'b0;
      m_left   <= 0;
      m_hits   <= 0;
      m_misses <= 0;
    end else if (rdy_in) begin
      if (m_resp) begin
        m_have <= 1'b1;
        m_inst <= mem_word({m_pc[31:2], 2'b00});
        m_resp <= 1'b0;
      end else if (m_left != 0) begin
        m_have <= 1'b0;
        if (mem_done) begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_req             <= 1'b0;
            m_valid[m_pc[7:4]] <= 1'b1;
            m_tag[m_pc[7:4]]   <= m_pc[31:8];
            m_resp            <= 1'b1;
          end else begin
            m_addr <= m_addr + 32'd4;
          end
        end
      end else begin
        m_have <= 1'b0;
        if (to_icache) begin
          m_pc <= pc_to_icache;
          if (m_valid[pc_to_icache[7:4]] && m_tag[pc_to_icache[7:4]] == pc_to_icache[31:8]) begin
            m_have <= 1'b1;
            m_inst <= mem_word({pc_to_icache[31:2], 2'b00});
            m_hits <= m_hits + 1;
          end else begin
            m_left   <= 4;
            m_req    <= 1'b1;
            m_addr   <= {pc_to_icache[31:4], 4'h0};
            m_misses <= m_misses + 1;
          end
        end
      end
    end
  end

  always @(negedge clk_in) begin
    chk("have_result", 32'(have_result), 32'(m_have));
    chk("inst", inst_from_icache, m_inst);
    chk("mem_req", 32'(mem_req), 32'(m_req));
    chk("mem_addr", mem_addr, m_addr);
`ifdef ICACHE_PERF_EN
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
`endif
  end

  task automatic req(input logic [31:0] pc);
    to_icache    = 1'b1;
    pc_to_icache = pc;
    @(negedge clk_in);
    to_icache = 1'b0;
  endtask

  task automatic await_result(input string name);
    int n = 0;
    while (have_result !== 1'b1 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    chk(name, 32'(have_result), 32'd1);
  endtask

  initial begin
    int dones;
    int n;
    #1 rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("rst_have", 32'(have_result), 32'd0);
    chk("rst_inst", inst_from_icache, 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Cold miss on 0x10
    seen.delete();
    req(32'h10);
    chk("cold_req_up", 32'(mem_req), 32'd1);
    await_result("cold_done");
    chk("cold_inst", inst_from_icache, 32'hA0);
    chk("cold_req_low", 32'(mem_req), 32'd0);
    chk("cold_nwords", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("cold_addr", seen[i], 32'h10 + 32'(4 * i));

    // Hit after refill: result one cycle later
    req(32'h18);
    chk("hit_have", 32'(have_result), 32'd1);
    chk("hit_inst", inst_from_icache, 32'hA2);
    chk("hit_noreq", 32'(mem_req), 32'd0);

    // Conflict eviction, with a stray request during refill that must be ignored
    req(32'h110);
    chk("evict_req", 32'(mem_req), 32'd1);
    @(negedge clk_in);
    req(32'h18);
    await_result("evict_done");
    chk("evict_inst", inst_from_icache, 32'h5A5A_0110);
    req(32'h10);
    chk("remiss_req", 32'(mem_req), 32'd1);
    await_result("remiss_done");
    chk("remiss_inst", inst_from_icache, 32'hA0);

    // Back-to-back hits, first one issued in the same cycle as the previous result
    to_icache    = 1'b1;
    pc_to_icache = 32'h10;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_in);
      chk("b2b_have", 32'(have_result), 32'd1);
      chk("b2b_inst", inst_from_icache, 32'hA0 + 32'(i - 1));
      if (i < 4) pc_to_icache = 32'h10 + 32'(4 * i);
      else to_icache = 1'b0;
    end

    // Pause after the second memory handshake
    seen.delete();
    req(32'h24);
    dones = 0;
    n = 0;
    while (dones < 2 && n < 200) begin
      @(negedge clk_in);
      if (mem_done) dones++;
      n++;
    end
    chk("pause_dones", 32'(dones), 32'd2);
    rdy_in = 1'b0;
    repeat (5) begin
      @(negedge clk_in);
      chk("pause_addr", mem_addr, 32'h28);
      chk("pause_req", 32'(mem_req), 32'd1);
    end
    rdy_in = 1'b1;
    await_result("pause_done");
    chk("pause_inst", inst_from_icache, 32'h5A5A_0024);
    chk("pause_nwords", 32'(seen.size()), 32'd4);

    // Asynchronous reset in the middle of a refill
    req(32'h30);
    @(negedge clk_in);
    #3 rst_in = 1'b1;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_have", 32'(have_result), 32'd0);
`ifdef ICACHE_PERF_EN
    chk("arst_hits", hit_count, 32'd0);
    chk("arst_misses", miss_count, 32'd0);
`endif
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    req(32'h30);
    chk("arst_miss", 32'(mem_req), 32'd1);
    await_result("arst_done");
    chk("arst_inst", inst_from_icache, 32'h5A5A_0030);
    req(32'h10);
    chk("arst_cold10", 32'(mem_req), 32'd1);
    await_result("arst10_done");
    chk("arst10_inst", inst_from_icache, 32'hA0);

    @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
